// File: rtl/regfile_alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : regfile_alu_datapath
// Purpose  : Sixteen 16-bit general registers, an ALU and a 5-bit flag
//            register. Each cycle it executes one control word
//            (opcode, register selects, immediate, write mask) and returns
//            condition flags to the controlling FSM.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            wEnable[15:0]    - destination mask, bit i writes r[i]
//            Imm_in[15:0]     - immediate operand
//            opcode[7:0]      - operation code
//            Rdest_sel[3:0]   - operand A = r[Rdest_sel]
//            Rsrc_sel[3:0]    - register operand B = r[Rsrc_sel]
//            Imm_sel          - 0: B = Imm_in, 1: B = r[Rsrc_sel]
//            dbg_sel[3:0]     - debug read select
//            Flags_out[4:0]   - {L, C, F, Z, N}
//            alu_result[15:0] - combinational ALU result
//            dbg_data[15:0]   - combinational r[dbg_sel]
// Revision : 1.0 - initial release
// ============================================================================
module regfile_alu_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] wEnable,
    input  logic [15:0] Imm_in,
    input  logic [7:0]  opcode,
    input  logic [3:0]  Rdest_sel,
    input  logic [3:0]  Rsrc_sel,
    input  logic        Imm_sel,
    input  logic [3:0]  dbg_sel,
    output logic [4:0]  Flags_out,
    output logic [15:0] alu_result,
    output logic [15:0] dbg_data
);

    localparam int unsigned C_NUM_REGS = 16;

    logic [15:0] r_regs [C_NUM_REGS];
    logic [4:0]  r_flags;

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [15:0] w_result;
    logic [4:0]  w_flags;
    logic        w_writes;
    logic        w_sets_flags;
    logic        w_lt_u;
    logic        w_lt_s;

    always_comb begin
        w_a    = r_regs[Rdest_sel];
        w_b    = Imm_sel ? r_regs[Rsrc_sel] : Imm_in;
        w_sum  = {1'b0, w_a} + {1'b0, w_b};
        // Borrow out of the 17-bit subtraction is exactly the unsigned A < B.
        w_diff = {1'b0, w_a} - {1'b0, w_b};
        w_lt_u = w_diff[16];
        w_lt_s = $signed(w_a) < $signed(w_b);

        w_result     = 16'h0000;
        w_flags      = 5'b00000;
        w_writes     = 1'b0;
        w_sets_flags = 1'b0;

        case (opcode)
            8'h06, 8'h60, 8'h05, 8'h50: begin
                w_result     = w_sum[15:0];
                w_flags      = {1'b0, w_sum[16],
                                (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]),
                                (w_sum[15:0] == 16'h0000), w_sum[15]};
                w_writes     = 1'b1;
                w_sets_flags = 1'b1;
            end
            8'h09, 8'h90, 8'h0B, 8'hB0: begin
                w_result     = w_diff[15:0];
                w_flags      = {w_lt_u, w_lt_u,
                                (w_a[15] != w_b[15]) && (w_diff[15] != w_a[15]),
                                (w_a == w_b), w_lt_s};
                // CMP shares the subtractor but never writes back.
                w_writes     = (opcode == 8'h09) || (opcode == 8'h90);
                w_sets_flags = 1'b1;
            end
            8'h01, 8'h10: begin
                w_result = w_a & w_b;
                w_writes = 1'b1;
            end
            8'h02, 8'h20: begin
                w_result = w_a | w_b;
                w_writes = 1'b1;
            end
            8'h03, 8'h30: begin
                w_result = w_a ^ w_b;
                w_writes = 1'b1;
            end
            8'h0D, 8'hD0: begin
                w_result = w_b;
                w_writes = 1'b1;
            end
            default: begin
                // NOP and unknown opcodes: result 0, no write, flags held.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_flags <= 5'b00000;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (w_writes && wEnable[i]) begin
                    r_regs[i] <= w_result;
                end
            end
            if (w_sets_flags) begin
                r_flags <= w_flags;
            end
        end
    end

    // Bypass lets a controller branch on CMP flags in the same cycle.
    assign Flags_out  = w_sets_flags ? w_flags : r_flags;
    assign alu_result = w_result;
    assign dbg_data   = r_regs[dbg_sel];

endmodule
`default_nettype wire
